// File: rtl/sig_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : sig_debounce_ch
// Purpose  : One debounce channel: 2-FF synchronizer, stability counter,
//            debounced level and one-clock rise/fall strobes.
// Revision : 1.0  initial release
// ============================================================================
module sig_debounce_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             sclr,
  input  logic             sig,
  input  logic             tick,
  input  logic [WIDTH-1:0] thr,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic             r_meta;
  logic             r_s;
  logic [WIDTH-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_meta  <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (sclr) begin
      r_meta  <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_meta <= sig;
      r_s    <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s == r_level) begin
        r_cnt <= '0;
      end else if (tick) begin
        // >= lets a lowered threshold take effect on the very next tick
        if (r_cnt >= thr) begin
          r_level <= r_s;
          r_cnt   <= '0;
          r_rise  <= r_s;
          r_fall  <= ~r_s;
        end else begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/sig_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sig_debounce
// Purpose  : Multi-channel debouncer with one shared tick prescaler.
// Revision : 1.0  initial release
// ============================================================================
module sig_debounce #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [CHANNELS-1:0]  sig,
  input  logic [PRE_WIDTH-1:0] scale,
  input  logic [WIDTH-1:0]     thr,
  output logic [CHANNELS-1:0]  level,
  output logic [CHANNELS-1:0]  rise,
  output logic [CHANNELS-1:0]  fall
);

  logic [PRE_WIDTH-1:0] r_pre;
  logic                 w_tick;

  assign w_tick = (r_pre == scale);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_pre <= '0;
    end else if (sclr) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_WIDTH'(1);
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sig_debounce_ch #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (sclr),
        .sig   (sig[i]),
        .tick  (w_tick),
        .thr   (thr),
        .level (level[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sig_debounce.sv
`default_nettype none
// Scoreboard bench for sig_debounce: directed steps queue the expected strobe
// (edge index, rise, fall, level); a monitor matches every strobe it sees.
module tb_sig_debounce;

  logic        clk = 1'b0;
  logic        aclr;
  logic        sclr;
  logic [3:0]  sig;
  logic [15:0] scale;
  logic [15:0] thr;
  logic [3:0]  level;
  logic [3:0]  rise;
  logic [3:0]  fall;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sig_debounce #(
    .CHANNELS  (4),
    .WIDTH     (16),
    .PRE_WIDTH (16)
  ) dut (
    .clk   (clk),
    .aclr  (aclr),
    .sclr  (sclr),
    .sig   (sig),
    .scale (scale),
    .thr   (thr),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_strobe(input int c, input logic [3:0] r,
                                        input logic [3:0] f, input logic [3:0] l);
    exp_t e;
    e.cyc   = c;
    e.rise  = r;
    e.fall  = f;
    e.level = l;
    q.push_back(e);
  endfunction

  // Clear everything with sclr, then apply v; k is the index of the clearing edge.
  task automatic restart(input logic [3:0] v, output int k);
    @(negedge clk);
    sclr = 1'b1;
    sig  = 4'b0000;
    @(negedge clk);
    sclr = 1'b0;
    sig  = v;
    k    = cyc;
  endtask

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: cyc counts rising edges; strobes are matched against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if ((rise | fall) != 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 32'({rise, fall}), 32'd0);
        end else begin
          e = q.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("strobe_rise", 32'(rise), 32'(e.rise));
          check("strobe_fall", 32'(fall), 32'(e.fall));
          check("strobe_level", 32'(level), 32'(e.level));
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe: none by cycle %0d, required at cycle %0d rise %0h fall %0h",
                 cyc, e.cyc, e.rise, e.fall);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    aclr  = 1'b1;
    sclr  = 1'b0;
    sig   = 4'b0000;
    scale = 16'd3;
    thr   = 16'd2;
    #12;
    check("reset_level", 32'(level), 32'd0);
    check("reset_rise", 32'(rise), 32'd0);
    check("reset_fall", 32'(fall), 32'd0);
    @(negedge clk);
    aclr = 1'b0;

    // Step on ch0, scale=3 thr=2: ticks every 4 edges, third qualifying tick
    restart(4'b0001, k);
    expect_strobe(k + 12, 4'b0001, 4'b0000, 4'b0001);
    wait_neg(k + 16);
    check("step_level", 32'(level), 32'h1);

    // Glitches on ch1: 1 clock, then 8 clocks (only two ticks of mismatch)
    @(negedge clk); sig[1] = 1'b1;
    @(negedge clk); sig[1] = 1'b0;
    repeat (3) @(negedge clk);
    sig[1] = 1'b1;
    repeat (8) @(negedge clk);
    sig[1] = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_level", 32'(level), 32'h1);

    // scale=0 thr=0: ch2 toggles every 5 clocks, level lags the synchronizer by 1
    scale = 16'd0;
    thr   = 16'd0;
    restart(4'b0000, k);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sig[2] = ~sig[2];
      expect_strobe(cyc + 3, sig[2] ? 4'b0100 : 4'b0000,
                    sig[2] ? 4'b0000 : 4'b0100, sig[2] ? 4'b0100 : 4'b0000);
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("toggle_level", 32'(level), 32'h0);

    // All channels together, scale=1 thr=4: five ticks at edges k+4..k+12
    scale = 16'd1;
    thr   = 16'd4;
    restart(4'b1111, k);
    expect_strobe(k + 12, 4'b1111, 4'b0000, 4'b1111);
    wait_neg(k + 16);
    check("all_level", 32'(level), 32'hF);

    // sclr one clock before qualification: partial count lost, full requalify
    scale = 16'd3;
    thr   = 16'd2;
    restart(4'b0001, k);
    wait_neg(k + 10);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    expect_strobe(k + 23, 4'b0001, 4'b0000, 4'b0001);
    @(negedge clk);
    check("sclr_level_held", 32'(level), 32'h0);
    wait_neg(k + 26);
    check("sclr_requal_level", 32'(level), 32'h1);

    // aclr mid-count clears outputs immediately, between clock edges
    @(negedge clk);
    sig = 4'b0000;
    repeat (6) @(negedge clk);
    check("pre_aclr_level", 32'(level), 32'h1);
    #2;
    aclr = 1'b1;
    #1;
    check("aclr_level", 32'(level), 32'h0);
    check("aclr_rise", 32'(rise), 32'h0);
    check("aclr_fall", 32'(fall), 32'h0);
    @(negedge clk);
    aclr = 1'b0;
    sig  = 4'b1000;
    thr  = 16'd10;
    k    = cyc;
    // cnt reaches 5 at edge k+20; lowering thr to 1 fires on the tick at k+24
    expect_strobe(k + 24, 4'b1000, 4'b0000, 4'b1000);
    wait_neg(k + 21);
    thr = 16'd1;
    wait_neg(k + 28);
    check("thr_drop_level", 32'(level), 32'h8);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
